// File: rtl/tff_count_ctrl.sv
// Modulo up/down counter sequencer for a bank of T flip-flops.
// Build option: TFF_COUNT_CTRL_SAT_EN makes the count saturate instead of wrap.
module tff_count_ctrl #(
  parameter int WIDTH       = 4,
  parameter bit ONESHOT_DEF = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             up_q, up_d;
  logic             one_q, one_d;
`ifdef TFF_COUNT_CTRL_SAT_EN
  logic             sat_q, sat_d;
`endif

  logic [WIDTH-1:0] m_last;
  logic [WIDTH-1:0] inc_vec;
  logic [WIDTH-1:0] dec_vec;
  logic [WIDTH-1:0] wrap_vec;
  logic [WIDTH-1:0] load_fit;
  logic             at_term;
  logic             hit;
  logic             unused_cfg;

  assign unused_cfg = ONESHOT_DEF;

  // A modulus of 0 underflows to all-ones, giving the natural binary wrap.
  assign m_last = mod_q - WIDTH'(1);

  always_comb begin
    inc_vec    = '0;
    dec_vec    = '0;
    inc_vec[0] = 1'b1;
    dec_vec[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_vec[i] = inc_vec[i-1] & q_q[i-1];
      dec_vec[i] = dec_vec[i-1] & ~q_q[i-1];
    end
  end

  assign at_term  = up_q ? (q_q == m_last) : (q_q == '0);
  assign wrap_vec = up_q ? q_q : (q_q ^ m_last);
  assign hit      = (state_q == S_RUN) && at_term && !stop;

  // Loads are fitted against the modulus currently on the port.
  assign load_fit = ((mod_val == '0) || (load_val < mod_val))
                  ? load_val : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mod_q   <= '0;
      up_q    <= 1'b0;
      one_q   <= 1'b0;
`ifdef TFF_COUNT_CTRL_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mod_q   <= mod_d;
      up_q    <= up_d;
      one_q   <= one_d;
`ifdef TFF_COUNT_CTRL_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mod_d   = mod_q;
    up_d    = up_q;
    one_d   = one_q;
`ifdef TFF_COUNT_CTRL_SAT_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          q_d = load_fit;
        end else if (start && !stop) begin
          mod_d   = mod_val;
          up_d    = up_dn;
          one_d   = oneshot;
          state_d = S_RUN;
        end
`ifdef TFF_COUNT_CTRL_SAT_EN
        sat_d = 1'b0;
`endif
      end
      S_RUN: begin
        q_d = q_q ^ t_vec;
        if (stop) begin
          state_d = S_IDLE;
        end else if (hit && one_q) begin
          state_d = S_DONE;
        end
`ifdef TFF_COUNT_CTRL_SAT_EN
        sat_d = (sat_q || tc) && (state_d == S_RUN);
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    t_vec = '0;
    busy  = 1'b0;
    tc    = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy = 1'b1;
        if (!stop) begin
          if (at_term) begin
`ifdef TFF_COUNT_CTRL_SAT_EN
            t_vec = '0;
            tc    = !sat_q;
`else
            t_vec = wrap_vec;
            tc    = 1'b1;
`endif
          end else begin
            t_vec = up_q ? inc_vec : dec_vec;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef TFF_COUNT_CTRL_SAT_EN
  logic [WIDTH-1:0] unused_wrap;
  assign unused_wrap = wrap_vec;
`endif

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed scoreboard bench for tff_count_ctrl (WIDTH = 4).
// Wrap tests run by default; saturation tests when TFF_COUNT_CTRL_SAT_EN is set.
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, up_dn, oneshot, load;
  logic [3:0] mod_val, load_val;
  logic [3:0] t_vec, q, qbar;
  logic       busy, tc, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] t;
    logic       b;
    logic       tc;
    logic       d;
    string      nm;
  } exp_t;

  exp_t sb[$];

  logic [3:0] up_tab [16] = '{
    4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF,
    4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF
  };

  tff_count_ctrl #(.WIDTH(4), .ONESHOT_DEF(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .up_dn(up_dn), .oneshot(oneshot), .mod_val(mod_val),
    .load(load), .load_val(load_val), .t_vec(t_vec),
    .q(q), .qbar(qbar), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input int eq, input int et, input int eb,
                      input int etc, input int ed, input string nm);
    exp_t e;
    e.q  = 4'(eq);
    e.t  = 4'(et);
    e.b  = (eb != 0);
    e.tc = (etc != 0);
    e.d  = (ed != 0);
    e.nm = nm;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs after the edge, queue expected outputs.
  task automatic cyc(input int st, input int sp, input int ld,
                     input int lv, input int eq, input int et,
                     input int eb, input int etc, input int ed,
                     input string nm);
    @(posedge clk);
    #1;
    start    = (st != 0);
    stop     = (sp != 0);
    load     = (ld != 0);
    load_val = 4'(lv);
    push(eq, et, eb, etc, ed, nm);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (q !== e.q || qbar !== ~e.q || t_vec !== e.t ||
          busy !== e.b || tc !== e.tc || done !== e.d) begin
        failures++;
        $display("FAIL %s: got q=%h qbar=%h t=%h busy=%b tc=%b done=%b want q=%h t=%h busy=%b tc=%b done=%b",
                 e.nm, q, qbar, t_vec, busy, tc, done,
                 e.q, e.t, e.b, e.tc, e.d);
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 0; stop = 0; load = 0; load_val = 0;
    up_dn = 1; oneshot = 0; mod_val = 4'd10;
    #12 rst = 1'b0;

    cyc(0,0,0,0,  0,0,0,0,0, "reset_state");
    cyc(1,0,0,0,  0,0,0,0,0, "start_idle");
    cyc(0,0,0,0,  0,1,1,0,0, "run_q0");
    cyc(0,0,0,0,  1,3,1,0,0, "run_q1");
    cyc(0,0,0,0,  2,1,1,0,0, "run_q2");
    cyc(0,0,0,0,  3,7,1,0,0, "run_q3");
    cyc(0,0,0,0,  4,1,1,0,0, "run_q4");
    cyc(0,0,0,0,  5,3,1,0,0, "run_q5");
    @(posedge clk);
    #1;
    push(0,0,0,0,0, "rst_async_q6");
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0,0,0,0,  0,0,0,0,0, "post_reset_idle");

    cyc(1,1,0,0,  0,0,0,0,0, "start_stop_idle");
    cyc(0,0,0,0,  0,0,0,0,0, "start_stop_stayed");
    cyc(0,0,1,8,  0,0,0,0,0, "ld8");
    cyc(1,0,0,0,  8,0,0,0,0, "ld8_result");
    cyc(0,0,0,0,  8,1,1,0,0, "sw_q8");
    cyc(0,1,0,0,  9,0,1,0,0, "stop_on_wrap");
    cyc(1,0,1,3,  9,0,0,0,0, "stop_hold_q9");
    cyc(0,0,0,0,  3,0,0,0,0, "load_beats_start");

`ifndef TFF_COUNT_CTRL_SAT_EN
    cyc(0,0,1,0,  3,0,0,0,0, "ld0");
    cyc(1,0,0,0,  0,0,0,0,0, "fr_start");
    cyc(0,0,0,0,  0,1,1,0,0, "fr_q0");
    cyc(0,0,0,0,  1,3,1,0,0, "fr_q1");
    cyc(0,0,0,0,  2,1,1,0,0, "fr_q2");
    cyc(0,0,0,0,  3,7,1,0,0, "fr_t0111");
    mod_val = 4'd3;
    up_dn   = 1'b0;
    cyc(0,0,0,0,  4,1,1,0,0, "fr_q4");
    cyc(0,0,0,0,  5,3,1,0,0, "fr_q5");
    cyc(0,0,0,0,  6,1,1,0,0, "fr_q6");
    cyc(0,0,0,0,  7,15,1,0,0, "fr_q7");
    cyc(0,0,0,0,  8,1,1,0,0, "fr_q8");
    cyc(0,0,0,0,  9,9,1,1,0, "fr_wrap_t1001");
    cyc(0,0,0,0,  0,1,1,0,0, "fr_after_wrap");
    cyc(0,0,0,0,  1,3,1,0,0, "fr_q1b");
    cyc(0,1,0,0,  2,0,1,0,0, "fr_stop");
    cyc(0,0,0,0,  2,0,0,0,0, "fr_idle");

    mod_val = 4'd5; up_dn = 1'b0; oneshot = 1'b1;
    cyc(0,0,1,7,  2,0,0,0,0, "ld7_m5");
    cyc(0,0,1,3,  0,0,0,0,0, "ld7_trunc0");
    cyc(1,0,0,0,  3,0,0,0,0, "os_start");
    cyc(0,0,0,0,  3,1,1,0,0, "os_q3");
    cyc(0,0,0,0,  2,3,1,0,0, "os_q2");
    cyc(0,0,0,0,  1,1,1,0,0, "os_q1");
    cyc(0,0,0,0,  0,4,1,1,0, "os_wrap_t0100");
    cyc(0,0,0,0,  4,0,0,0,1, "os_done");
    cyc(0,0,0,0,  4,0,0,0,0, "os_idle");

    mod_val = 4'd0; up_dn = 1'b1; oneshot = 1'b0;
    cyc(0,0,1,0,  4,0,0,0,0, "ld0_m0");
    cyc(1,0,0,0,  0,0,0,0,0, "m0_start");
    for (int i = 0; i < 16; i++)
      cyc(0,0,0,0, i, int'(up_tab[i]), 1, (i == 15) ? 1 : 0, 0, "m0_run");
    cyc(0,0,0,0,  0,1,1,0,0, "m0_after_wrap");
    cyc(0,1,0,0,  1,0,1,0,0, "m0_stop");

    mod_val = 4'd10;
    cyc(0,0,1,12, 1,0,0,0,0, "ld12_m10");
    cyc(0,0,0,0,  0,0,0,0,0, "ld12_trunc0");

    mod_val = 4'd1;
    cyc(1,0,0,0,  0,0,0,0,0, "m1_start");
    cyc(0,0,0,0,  0,0,1,1,0, "m1_wrap_a");
    cyc(0,0,0,0,  0,0,1,1,0, "m1_wrap_b");
    cyc(0,1,0,0,  0,0,1,0,0, "m1_stop");
    cyc(0,0,0,0,  0,0,0,0,0, "m1_idle");
`else
    mod_val = 4'd10; up_dn = 1'b1; oneshot = 1'b0;
    cyc(0,0,1,7,  3,0,0,0,0, "sat_ld7");
    cyc(1,0,0,0,  7,0,0,0,0, "sat_start");
    cyc(0,0,0,0,  7,15,1,0,0, "sat_q7");
    cyc(0,0,0,0,  8,1,1,0,0, "sat_q8");
    cyc(0,0,0,0,  9,0,1,1,0, "sat_tc");
    cyc(0,0,0,0,  9,0,1,0,0, "sat_hold_a");
    cyc(0,0,0,0,  9,0,1,0,0, "sat_hold_b");
    cyc(0,1,0,0,  9,0,1,0,0, "sat_stop");
    cyc(0,0,0,0,  9,0,0,0,0, "sat_idle");

    mod_val = 4'd5; up_dn = 1'b0; oneshot = 1'b1;
    cyc(0,0,1,2,  9,0,0,0,0, "sat_ld2");
    cyc(1,0,0,0,  2,0,0,0,0, "sat_os_start");
    cyc(0,0,0,0,  2,3,1,0,0, "sat_os_q2");
    cyc(0,0,0,0,  1,1,1,0,0, "sat_os_q1");
    cyc(0,0,0,0,  0,0,1,1,0, "sat_os_term");
    cyc(0,0,0,0,  0,0,0,0,1, "sat_os_done");
    cyc(0,0,0,0,  0,0,0,0,0, "sat_os_idle");
`endif

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
